rsa_avalon_wrapper: RTL and testbench



---
 rtl/rsa_pkg.sv | 15 +
 rtl/rsa_avalon_wrapper_xfer.sv | 42 ++++
 rtl/rsa_avalon_wrapper.sv | 114 +++++++++++
 tb/tb_rsa_avalon_wrapper.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state/phase types, UART register map and status bits for the RSA Avalon wrapper.
package rsa_pkg;
  typedef enum logic [2:0] {S_POLL_RX, S_READ_RX, S_START, S_WAIT_CORE, S_POLL_TX, S_WRITE_TX} state_t;
  typedef enum logic [1:0] {PH_N, PH_D, PH_A} phase_t;
  localparam int BYTES_IN_DEF = 32;
  localparam int BYTES_OUT_DEF = 31;
  localparam logic [4:0] RX_BASE_DEF = 5'd0;
  localparam logic [4:0] TX_BASE_DEF = 5'd4;
  localparam logic [4:0] STATUS_BASE_DEF = 5'd8;
  localparam int RX_OK_BIT_DEF = 7;
  localparam int TX_OK_BIT_DEF = 6;
  function automatic logic is_bus(input state_t s);
    return s inside {S_POLL_RX, S_READ_RX, S_POLL_TX, S_WRITE_TX};
  endfunction
endpackage

// File: rtl/rsa_avalon_wrapper_xfer.sv
// avm_byte_xfer: one Avalon read or write, held through waitrequest; done pulses in the completing cycle.
module avm_byte_xfer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        go,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [7:0]  wdata,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic [31:0] avm_readdata_unused_guard,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata
);
  import rsa_pkg::*;
  assign busy = avm_read | avm_write;
  assign done = busy & ~avm_waitrequest;
  assign rdata = avm_readdata[7:0];
  assign avm_readdata_unused_guard = {avm_readdata[31:8], 8'd0};
  // a new request may only be launched when idle or in the cycle the current one completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      avm_address <= STATUS_BASE_DEF;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= 32'd0;
    end else if (go) begin
      avm_address <= addr;
      avm_read <= ~wr;
      avm_write <= wr;
      avm_writedata <= {24'd0, wdata};
    end else if (done) begin
      avm_read <= 1'b0;
      avm_write <= 1'b0;
    end
  end
endmodule

// File: rtl/rsa_avalon_wrapper.sv
// rsa_avalon_wrapper: polls the UART for N, d and ciphertext blocks, runs the RSA core, returns plaintext.
// Optional block counter output o_blk_cnt when RSA_WRAPPER_BLK_CNT_EN is defined.
module rsa_avalon_wrapper
  import rsa_pkg::*;
#(
  parameter int         BYTES_IN    = BYTES_IN_DEF,
  parameter int         BYTES_OUT   = BYTES_OUT_DEF,
  parameter logic [4:0] RX_BASE     = RX_BASE_DEF,
  parameter logic [4:0] TX_BASE     = TX_BASE_DEF,
  parameter logic [4:0] STATUS_BASE = STATUS_BASE_DEF,
  parameter int         RX_OK_BIT   = RX_OK_BIT_DEF,
  parameter int         TX_OK_BIT   = TX_OK_BIT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
`ifdef RSA_WRAPPER_BLK_CNT_EN
  ,
  output logic [15:0]  o_blk_cnt
`endif
);
  localparam logic [4:0] LAST_IN = 5'(BYTES_IN - 1);
  localparam logic [4:0] LAST_OUT = 5'(BYTES_OUT - 1);
  state_t state, tgt;
  phase_t phase;
  logic [4:0] cnt;
  logic [247:0] tx;
  logic go, wr, busy, done, last_in, last_out;
  logic [4:0] addr;
  logic [7:0] rdata;
  logic [31:0] rd_hi;
  logic unused_bits;
  assign unused_bits = ^{i_core_a_pow_d[255:248], rd_hi};
  assign last_in = cnt == LAST_IN;
  assign last_out = cnt == LAST_OUT;
  always_comb begin
    tgt = state;
    case (state)
      S_POLL_RX:   tgt = done && rdata[RX_OK_BIT] ? S_READ_RX : S_POLL_RX;
      S_READ_RX:   tgt = !done ? S_READ_RX : last_in && phase == PH_A ? S_START : S_POLL_RX;
      S_START:     tgt = S_WAIT_CORE;
      S_WAIT_CORE: tgt = i_core_finished ? S_POLL_TX : S_WAIT_CORE;
      S_POLL_TX:   tgt = done && rdata[TX_OK_BIT] ? S_WRITE_TX : S_POLL_TX;
      S_WRITE_TX:  tgt = !done ? S_WRITE_TX : last_out ? S_POLL_RX : S_POLL_TX;
      default:     tgt = S_POLL_RX;
    endcase
  end
  // the bus request always belongs to the state being entered, so polls re-issue back-to-back
  assign go = is_bus(tgt) && (!busy || done);
  assign wr = tgt == S_WRITE_TX;
  assign addr = tgt == S_READ_RX ? RX_BASE : wr ? TX_BASE : STATUS_BASE;
  avm_byte_xfer u_xfer (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .go(go),
    .wr(wr),
    .addr(addr),
    .wdata(tx[247:240]),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata_unused_guard(rd_hi),
    .avm_readdata(avm_readdata),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy),
    .done(done),
    .rdata(rdata)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_POLL_RX;
      phase <= PH_N;
      cnt <= 5'd0;
      o_core_start <= 1'b0;
      o_core_n <= '0;
      o_core_d <= '0;
      o_core_a <= '0;
      tx <= '0;
    end else begin
      state <= tgt;
      o_core_start <= tgt == S_START;
      if (state == S_READ_RX && done) begin
        o_core_n <= phase == PH_N ? {o_core_n[247:0], rdata} : o_core_n;
        o_core_d <= phase == PH_D ? {o_core_d[247:0], rdata} : o_core_d;
        o_core_a <= phase == PH_A ? {o_core_a[247:0], rdata} : o_core_a;
        cnt <= last_in ? 5'd0 : cnt + 5'd1;
        if (last_in && phase != PH_A) phase <= phase == PH_N ? PH_D : PH_A;
      end
      if (state == S_WAIT_CORE && i_core_finished) tx <= i_core_a_pow_d[247:0];
      if (state == S_WRITE_TX && done) begin
        tx <= {tx[239:0], 8'd0};
        cnt <= last_out ? 5'd0 : cnt + 5'd1;
      end
    end
  end
`ifdef RSA_WRAPPER_BLK_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_blk_cnt <= 16'd0;
    else if (state == S_WRITE_TX && done && last_out) o_blk_cnt <= o_blk_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rsa_avalon_wrapper.sv
// tb_rsa_avalon_wrapper: UART/core models driven by a scenario table plus a mid-load reset sequence.
module tb_rsa_avalon_wrapper;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [4:0] avm_address;
  logic avm_read, avm_write, o_core_start;
  logic [31:0] avm_readdata = 32'd0, avm_writedata;
  logic avm_waitrequest = 1'b1, i_core_finished = 1'b0;
  logic [255:0] o_core_a, o_core_d, o_core_n, i_core_a_pow_d = '0;
`ifdef RSA_WRAPPER_BLK_CNT_EN
  logic [15:0] o_blk_cnt;
`endif
  always #5 i_clk = ~i_clk;
  rsa_avalon_wrapper dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .o_core_start(o_core_start),
    .o_core_a(o_core_a),
    .o_core_d(o_core_d),
    .o_core_n(o_core_n),
    .i_core_a_pow_d(i_core_a_pow_d),
    .i_core_finished(i_core_finished)
`ifdef RSA_WRAPPER_BLK_CNT_EN
    ,
    .o_blk_cnt(o_blk_cnt)
`endif
  );
  typedef struct {
    int not_ready;
    int max_stall;
    int core_delay;
    int nblk;
    int exp_wr;
    int exp_st;
    int exp_blk;
  } scn_t;
  scn_t tbl[5];
  int n_chk = 0, n_fail = 0;
  int not_ready = 0, max_stall = 0, core_delay = 3;
  logic [7:0] rxq[$], txq[$];
  int rx_cnt, starts, viol, bad_rx, bad_start, busy_act, rx_wait, stall, cd;
  bit rx_avail, in_xfer, core_busy, spur, ok;
  logic [4:0] s_addr;
  logic s_rd, s_wr;
  logic [31:0] s_wd;
  logic [255:0] n_v, d_v, a_v[2];

  function automatic logic [255:0] pmodel(input logic [255:0] a);
    return {a[127:0], a[255:128]} ^ {8{32'hA5C3_1E77}};
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // UART slave with random stalls, then the RSA core model
  always @(negedge i_clk) begin
    if (i_rst) begin
      in_xfer = 0;
      avm_waitrequest = 1'b1;
      i_core_finished = 1'b0;
      core_busy = 0;
    end else begin
      if (avm_read || avm_write) begin
        if (avm_read && avm_write) viol++;
        if (core_busy && !i_core_finished) busy_act++;
        if (!in_xfer) begin
          in_xfer = 1;
          stall = $urandom_range(max_stall, 0);
          {s_addr, s_rd, s_wr, s_wd} = {avm_address, avm_read, avm_write, avm_writedata};
        end else if ({s_addr, s_rd, s_wr, s_wd} != {avm_address, avm_read, avm_write, avm_writedata}) viol++;
        if (stall > 0) begin
          stall--;
          avm_waitrequest = 1'b1;
          avm_readdata = 32'hDEAD_BEEF;
        end else begin
          avm_waitrequest = 1'b0;
          in_xfer = 0;
          if (avm_write) begin
            if (avm_address != 5'd4 || avm_writedata[31:8] != 24'd0) viol++;
            txq.push_back(avm_writedata[7:0]);
          end else if (avm_address == 5'd8) begin
            ok = rx_wait == 0 && rxq.size() > 0;
            avm_readdata = {24'd0, ok, 1'b1, 6'd0};
            if (ok) rx_avail = 1;
            else if (rx_wait > 0) rx_wait--;
          end else if (avm_address == 5'd0) begin
            if (!rx_avail || rxq.size() == 0) begin
              bad_rx++;
              avm_readdata = 32'd0;
            end else avm_readdata = {24'd0, rxq.pop_front()};
            rx_avail = 0;
            rx_wait = not_ready;
            rx_cnt++;
          end else viol++;
        end
      end else begin
        if (in_xfer) viol++;
        in_xfer = 0;
        avm_waitrequest = 1'b1;
      end
      if (o_core_start && core_busy) bad_start++;
      if (i_core_finished) begin
        i_core_finished = 1'b0;
        i_core_a_pow_d = ~i_core_a_pow_d;
        core_busy = 0;
      end else if (core_busy) begin
        if (cd <= 1) begin
          i_core_finished = 1'b1;
          i_core_a_pow_d = pmodel(o_core_a);
        end else cd--;
      end else if (o_core_start) begin
        starts++;
        if (rx_cnt != 64 + 32 * starts) bad_start++;
        core_busy = 1;
        cd = core_delay;
      end else if (rx_cnt == 50 && !spur) begin
        spur = 1;
        i_core_finished = 1'b1;
        i_core_a_pow_d = '1;
      end
    end
  end

  task automatic clear_model();
    rxq.delete();
    txq.delete();
    {rx_cnt, starts, viol, bad_rx, bad_start, busy_act} = '0;
    rx_wait = not_ready;
    rx_avail = 0;
    spur = 0;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    logic [7:0] exp_q[$];
    logic [255:0] p;
    int err, cyc;
    i_rst = 1'b1;
    not_ready = s.not_ready;
    max_stall = s.max_stall;
    core_delay = s.core_delay;
    clear_model();
    repeat (2) @(negedge i_clk);
    for (int i = 31; i >= 0; i--) rxq.push_back(n_v[8*i+:8]);
    for (int i = 31; i >= 0; i--) rxq.push_back(d_v[8*i+:8]);
    for (int b = 0; b < s.nblk; b++) begin
      for (int i = 31; i >= 0; i--) rxq.push_back(a_v[b][8*i+:8]);
      p = pmodel(a_v[b]);
      for (int i = 30; i >= 0; i--) exp_q.push_back(p[8*i+:8]);
    end
    #2 i_rst = 1'b0;
    cyc = 0;
    while (txq.size() < s.exp_wr && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
    end
    repeat (30) @(negedge i_clk);
    err = 0;
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) if (txq[i] !== exp_q[i]) err++;
    check($sformatf("s%0d_n", idx), o_core_n, n_v);
    check($sformatf("s%0d_d", idx), o_core_d, d_v);
    check($sformatf("s%0d_a", idx), o_core_a, a_v[s.nblk-1]);
    check($sformatf("s%0d_starts", idx), starts, s.exp_st);
    check($sformatf("s%0d_tx_count", idx), txq.size(), s.exp_wr);
    check($sformatf("s%0d_tx_bytes_bad", idx), err, 0);
    check($sformatf("s%0d_rx_count", idx), rx_cnt, 64 + 32 * s.nblk);
    check($sformatf("s%0d_bus_viol", idx), viol, 0);
    check($sformatf("s%0d_rx_not_ready_reads", idx), bad_rx, 0);
    check($sformatf("s%0d_start_errs", idx), bad_start, 0);
    check($sformatf("s%0d_bus_in_wait", idx), busy_act, 0);
`ifdef RSA_WRAPPER_BLK_CNT_EN
    check($sformatf("s%0d_blk_cnt", idx), o_blk_cnt, s.exp_blk);
`endif
  endtask

  initial begin
    int cyc;
    n_v = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
    d_v = (256'h0B50 << 240) | 256'h01;
    a_v[0] = 256'h0123456789ABCDEF_FEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
    a_v[1] = 256'h5A5A0F0F_3C3C9696_DEADC0DE_F00DFACE_0BADBEEF_13572468_ACE0BDF1_7E57AB1E;
    tbl[0] = '{0, 0, 3, 1, 31, 1, 1};
    tbl[1] = '{5, 0, 3, 1, 31, 1, 1};
    tbl[2] = '{0, 7, 3, 1, 31, 1, 1};
    tbl[3] = '{2, 3, 1000, 2, 62, 2, 2};
    tbl[4] = '{1, 2, 10, 1, 31, 1, 1};
    // load junk into the d phase, then hit reset asynchronously mid-transfer
    not_ready = 0;
    max_stall = 2;
    core_delay = 5;
    clear_model();
    for (int i = 0; i < 100; i++) rxq.push_back(8'(i * 7 + 3));
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b0;
    cyc = 0;
    while (rx_cnt < 40 && cyc < 5000) begin
      @(negedge i_clk);
      cyc++;
    end
    check("mr_reached_byte40", rx_cnt, 40);
    check("mr_n_loaded", o_core_n != 256'd0, 1);
    #3 i_rst = 1'b1;
    #1;
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_address", avm_address, 8);
    check("rst_writedata", avm_writedata, 0);
    check("rst_start", o_core_start, 0);
    check("rst_n", o_core_n, 0);
    check("rst_d", o_core_d, 0);
    check("rst_a", o_core_a, 0);
`ifdef RSA_WRAPPER_BLK_CNT_EN
    check("rst_blk_cnt", o_blk_cnt, 0);
`endif
    for (int i = 0; i < 5; i++) run_scn(i, tbl[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
